// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program-counter register with a PC+INC incrementer and a small
//            circular return-address stack (RAS) for call/return.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int                 WIDTH     = 16,
  parameter logic [WIDTH-1:0]   RESET_PC  = '0,
  parameter int                 INC       = 2,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] NEXT_PC,
  input  logic             PC_WRITE,
  input  logic             PC_WRITE_COND,
  input  logic             ZERO,
  input  logic             PUSH,
  input  logic             POP,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_INC,
  output logic [WIDTH-1:0] RA_TOP,
  output logic [2:0]       RAS_COUNT,
  output logic             RAS_OVF,
  output logic             RAS_UNF
);

  // Pointer addresses the RAS entries; the count port is 3 bits, which
  // bounds RAS_DEPTH to at most 4 for a power-of-two stack.
  localparam int             PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [WIDTH-1:0] C_INC = WIDTH'(INC);
  localparam logic [2:0]     C_FULL  = 3'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q,  pc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  logic             load;
  logic             empty;
  logic             full;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;

  assign PC_INC  = pc_q + C_INC;  // carry out is intentionally dropped
  assign load    = PC_WRITE | (PC_WRITE_COND & ZERO);
  assign empty   = (cnt_q == 3'd0);
  assign full    = (cnt_q == C_FULL);
  assign top_inc = top_q + 1'b1;
  assign top_dec = top_q - 1'b1;

  // Next-state logic for the PC and the return-address stack
  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    ras_d = ras_q;

    if (load) begin
      pc_d = NEXT_PC;
    end

    if (PUSH && POP && !empty) begin
      // Tail call style: replace the current return address in place.
      ras_d[top_q] = PC_INC;
    end else if (PUSH) begin
      // When full the pointer wraps onto the oldest entry, losing it.
      ras_d[top_inc] = PC_INC;
      top_d          = top_inc;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end else if (POP) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        top_d = top_dec;
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_PC;
      top_q <= '0;
      cnt_q <= 3'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign PC        = pc_q;
  assign RA_TOP    = empty ? '0 : ras_q[top_q];
  assign RAS_COUNT = cnt_q;
  assign RAS_OVF   = ovf_q;
  assign RAS_UNF   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Self-checking bench for pc_unit against a queue-based model of
//            the program counter and return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        CLK;
  logic        RST_N;
  logic [15:0] NEXT_PC;
  logic        PC_WRITE;
  logic        PC_WRITE_COND;
  logic        ZERO;
  logic        PUSH;
  logic        POP;
  logic [15:0] PC;
  logic [15:0] PC_INC;
  logic [15:0] RA_TOP;
  logic [2:0]  RAS_COUNT;
  logic        RAS_OVF;
  logic        RAS_UNF;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: a return-address list, newest at the back
  int          m_pc;
  logic [15:0] m_stack [$];
  bit          m_ovf;
  bit          m_unf;

  pc_unit #(
    .WIDTH    (16),
    .RESET_PC (16'h0000),
    .INC      (2),
    .RAS_DEPTH(4)
  ) u_dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .NEXT_PC      (NEXT_PC),
    .PC_WRITE     (PC_WRITE),
    .PC_WRITE_COND(PC_WRITE_COND),
    .ZERO         (ZERO),
    .PUSH         (PUSH),
    .POP          (POP),
    .PC           (PC),
    .PC_INC       (PC_INC),
    .RA_TOP       (RA_TOP),
    .RAS_COUNT    (RAS_COUNT),
    .RAS_OVF      (RAS_OVF),
    .RAS_UNF      (RAS_UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc  = 0;
    m_stack.delete();
    m_ovf = 0;
    m_unf = 0;
  endfunction

  // Model one clock edge from the current inputs
  function automatic void model_step();
    logic [15:0] ret;
    ret = 16'((m_pc + 2) % 65536);
    if (PUSH && POP && m_stack.size() > 0) begin
      m_stack[m_stack.size()-1] = ret;
    end else if (PUSH) begin
      m_stack.push_back(ret);
      if (m_stack.size() > 4) begin
        void'(m_stack.pop_front());
        m_ovf = 1;
      end
    end else if (POP) begin
      if (m_stack.size() == 0) m_unf = 1;
      else void'(m_stack.pop_back());
    end
    if (PC_WRITE || (PC_WRITE_COND && ZERO)) m_pc = int'(NEXT_PC);
  endfunction

  task automatic check_all(input string tag);
    logic [15:0] exp_top;
    exp_top = (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : 16'h0000;
    check({tag, ".pc"},     32'(PC),        32'(m_pc));
    check({tag, ".pcinc"},  32'(PC_INC),    32'((m_pc + 2) % 65536));
    check({tag, ".ratop"},  32'(RA_TOP),    32'(exp_top));
    check({tag, ".count"},  32'(RAS_COUNT), 32'(m_stack.size()));
    check({tag, ".ovf"},    32'(RAS_OVF),   32'(m_ovf));
    check({tag, ".unf"},    32'(RAS_UNF),   32'(m_unf));
  endtask

  task automatic cyc(input string tag, input logic [15:0] nxt, input logic wr,
                     input logic wrc, input logic z, input logic psh, input logic pp);
    NEXT_PC       = nxt;
    PC_WRITE      = wr;
    PC_WRITE_COND = wrc;
    ZERO          = z;
    PUSH          = psh;
    POP           = pp;
    model_step();
    @(posedge CLK);
    #1;
    NEXT_PC = '0; PC_WRITE = 0; PC_WRITE_COND = 0; ZERO = 0; PUSH = 0; POP = 0;
    check_all(tag);
  endtask

  task automatic set_pc(input logic [15:0] v);
    cyc("setpc", v, 1, 0, 0, 0, 0);
  endtask

  initial begin
    RST_N = 0; NEXT_PC = '0; PC_WRITE = 0; PC_WRITE_COND = 0;
    ZERO = 0; PUSH = 0; POP = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 check_all("in_reset");
    @(negedge CLK);
    RST_N = 1;
    @(posedge CLK); #1;

    // Idle after reset
    for (int i = 0; i < 3; i++) cyc("idle", 16'h1234, 0, 0, 0, 0, 0);

    // Load paths
    cyc("load",       16'h0040, 1, 0, 0, 0, 0);
    cyc("cond_nz",    16'h0100, 0, 1, 0, 0, 0);
    cyc("cond_z",     16'h0100, 0, 1, 1, 0, 0);

    // Call and return
    set_pc(16'h0010);
    cyc("call",       16'h0200, 1, 0, 0, 1, 0);
    check("call_ra", 32'(RA_TOP), 32'h0012);
    cyc("ret",        RA_TOP,   1, 0, 0, 0, 1);
    check("ret_pc", 32'(PC), 32'h0012);

    // Overflow: five calls from PCs 0000..0008
    set_pc(16'h0000);
    for (int i = 0; i < 5; i++) cyc("ovf_push", 16'(2 * (i + 1)), 1, 0, 0, 1, 0);
    check("ovf_top", 32'(RA_TOP), 32'h000A);
    for (int i = 0; i < 4; i++) cyc("ovf_pop", 16'h0000, 0, 0, 0, 0, 1);

    // Underflow and simultaneous push/pop
    cyc("unf_pop", 16'h0000, 0, 0, 0, 0, 1);
    set_pc(16'h0030);
    cyc("push30",  16'h0050, 1, 0, 0, 1, 0);
    cyc("pushpop", 16'h0000, 0, 0, 0, 1, 1);
    check("pp_top", 32'(RA_TOP), 32'h0052);

    // Wrap of the incrementer
    set_pc(16'hFFFE);
    check("wrap_inc", 32'(PC_INC), 32'h0000);
    cyc("push2",   16'h0000, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-cycle
    @(negedge CLK);
    #2 RST_N = 0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge CLK);
    RST_N = 1;

    // Randomized operation mix
    for (int i = 0; i < 400; i++) begin
      logic [15:0] nxt;
      int          r;
      nxt = 16'($urandom) & 16'hFFFE;
      r   = int'($urandom_range(0, 99));
      cyc("rand", nxt, r < 30, ($urandom_range(0, 3) == 0), 1'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      if (i == 200) begin
        @(negedge CLK);
        #3 RST_N = 0;
        model_reset();
        #1 check_all("rand_rst");
        @(negedge CLK);
        RST_N = 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
